router_src_rx: RTL and testbench

- Router-side receiver for the source-port packet protocol: pkt_valid, data_in, busy and error.
- Decodes the header, steers header, payload and parity bytes into one of NUM_DEST destination FIFOs, and applies backpressure via busy.
- Checks byte-wise XOR parity and payload length, and reports mismatches on error.
- Sits between the source port and the three output FIFOs of the 1x3 router.

---
 rtl/router_pkg.sv | 33 +++
 rtl/router_parity_acc.sv | 41 ++++
 rtl/router_src_rx.sv | 190 +++++++++++++++++++
 tb/tb_router_src_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, defaults and header helpers for the router source receiver
//
// Purpose : receiver FSM state encoding, default widths, header field layout
//           and helpers that split a header byte into address and length.
// Ports   : none (package).

package router_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;

   // Header layout: address in the low bits, length above it.
   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_LEN_LSB  = ADDR_W_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DROP  = 2'd3
   } rx_state_e;

   // Widths are passed in so the helpers serve any DATA_W/ADDR_W override;
   // callers cast the 32-bit result down to their field width.
   function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_w);
      return (hdr >> HDR_ADDR_LSB) & ((32'd1 << addr_w) - 32'd1);
   endfunction

   function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w);
      return hdr >> addr_w;
   endfunction

endpackage

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - byte-wise XOR parity accumulator with compare
//
// Purpose : holds the running XOR of a packet's header and payload bytes.
// Ports   : clock, resetn  - clock and async active-low reset
//           i_clr          - clear accumulator to zero
//           i_load         - load i_data (start of packet)
//           i_acc          - XOR i_data into accumulator
//           i_data         - byte to load/accumulate
//           i_cmp          - value compared against the accumulator
//           o_match        - accumulator equals i_cmp

module router_parity_acc #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic              i_acc,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_cmp,
   output logic              o_match
);

   logic [DATA_W-1:0] r_parity;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_parity <= '0;
      end else if (i_clr) begin
         r_parity <= '0;
      end else if (i_load) begin
         r_parity <= i_data;
      end else if (i_acc) begin
         r_parity <= r_parity ^ i_data;
      end
   end

   assign o_match = (r_parity == i_cmp);

endmodule

// File: rtl/router_src_rx.sv
// rtl/router_src_rx.sv - source-port packet receiver steering bytes into destination FIFOs
//
// Purpose : decodes the header, writes header/payload/parity bytes into the
//           addressed FIFO with zero latency, stalls the source on FIFO full,
//           and flags parity, length and address errors.
// Ports   : clock, resetn   - clock and async active-low reset
//           pkt_valid       - high for header/payload, low for parity byte
//           data_in         - packet byte from the source
//           busy            - backpressure to the source
//           error           - error status of the last completed packet
//           fifo_full       - per-destination FIFO full flags
//           wr_en, wr_data  - one-hot FIFO write strobe and byte
//           pkt_done        - one-cycle pulse when a packet completes

module router_src_rx
   import router_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_DEST = 3
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                pkt_valid,
   input  logic [DATA_W-1:0]   data_in,
   output logic                busy,
   output logic                error,
   input  logic [NUM_DEST-1:0] fifo_full,
   output logic [NUM_DEST-1:0] wr_en,
   output logic [DATA_W-1:0]   wr_data,
   output logic                pkt_done
);

   localparam int LEN_W = DATA_W - ADDR_W;

   rx_state_e           r_state;
   rx_state_e           w_next;
   logic [ADDR_W-1:0]   r_dest;
   logic [LEN_W-1:0]    r_length;
   logic [LEN_W-1:0]    r_count;
   logic [DATA_W-1:0]   r_rx_parity;
   logic                r_error;
   logic                r_pkt_done;

   logic [ADDR_W-1:0]   w_hdr_addr;
   logic [LEN_W-1:0]    w_hdr_len;
   logic                w_addr_ok;
   logic [NUM_DEST-1:0] w_oh_hdr;
   logic [NUM_DEST-1:0] w_oh_dest;
   logic                w_hdr_full;
   logic                w_dest_full;
   logic                w_busy;
   logic [NUM_DEST-1:0] w_wr_en;
   logic                w_hdr_ok;
   logic                w_hdr_bad;
   logic                w_pay;
   logic                w_par;
   logic                w_check;
   logic                w_drop_end;
   logic                w_par_match;

   assign w_hdr_addr = ADDR_W'(hdr_addr(32'(data_in), ADDR_W));
   assign w_hdr_len  = LEN_W'(hdr_len(32'(data_in), ADDR_W));
   assign w_addr_ok  = (int'(w_hdr_addr) < NUM_DEST);

   always_comb begin
      w_oh_hdr  = '0;
      w_oh_dest = '0;
      for (int i = 0; i < NUM_DEST; i++) begin
         w_oh_hdr[i]  = (int'(w_hdr_addr) == i);
         w_oh_dest[i] = (int'(r_dest) == i);
      end
   end

   assign w_hdr_full  = |(w_oh_hdr & fifo_full);
   assign w_dest_full = |(w_oh_dest & fifo_full);

   always_comb begin
      w_next     = r_state;
      w_busy     = 1'b0;
      w_wr_en    = '0;
      w_hdr_ok   = 1'b0;
      w_hdr_bad  = 1'b0;
      w_pay      = 1'b0;
      w_par      = 1'b0;
      w_check    = 1'b0;
      w_drop_end = 1'b0;
      case (r_state)
         IDLE: begin
            if (pkt_valid) begin
               if (!w_addr_ok) begin
                  w_hdr_bad = 1'b1;
                  w_next    = DROP;
               end else if (w_hdr_full) begin
                  w_busy = 1'b1;
               end else begin
                  w_wr_en  = w_oh_hdr;
                  w_hdr_ok = 1'b1;
                  w_next   = LOAD;
               end
            end
         end
         LOAD: begin
            if (w_dest_full) begin
               w_busy = 1'b1;
            end else begin
               w_wr_en = w_oh_dest;
               if (pkt_valid) begin
                  w_pay = 1'b1;
               end else begin
                  w_par  = 1'b1;
                  w_next = CHECK;
               end
            end
         end
         CHECK: begin
            w_busy  = 1'b1;
            w_check = 1'b1;
            w_next  = IDLE;
         end
         DROP: begin
            if (!pkt_valid) begin
               w_drop_end = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Combinational outputs are masked by reset so they fall the moment
   // resetn asserts, not at the next clock edge.
   assign busy     = resetn & w_busy;
   assign wr_en    = resetn ? w_wr_en : '0;
   assign wr_data  = (|wr_en) ? data_in : '0;
   assign error    = r_error;
   assign pkt_done = r_pkt_done;

   router_parity_acc #(
      .DATA_W (DATA_W)
   ) u_parity (
      .clock   (clock),
      .resetn  (resetn),
      .i_clr   (w_hdr_bad),
      .i_load  (w_hdr_ok),
      .i_acc   (w_pay),
      .i_data  (data_in),
      .i_cmp   (r_rx_parity),
      .o_match (w_par_match)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_dest      <= '0;
         r_length    <= '0;
         r_count     <= '0;
         r_rx_parity <= '0;
         r_error     <= 1'b0;
         r_pkt_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         // Pulse lands in the CHECK cycle for written packets and in the
         // following IDLE cycle for dropped ones.
         r_pkt_done <= w_par | w_drop_end;
         if (w_hdr_ok) begin
            r_dest   <= w_hdr_addr;
            r_length <= w_hdr_len;
            r_count  <= '0;
            r_error  <= 1'b0;
         end
         if (w_hdr_bad) begin
            r_error <= 1'b0;
         end
         if (w_pay && (r_count != {LEN_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
         end
         if (w_par) begin
            r_rx_parity <= data_in;
         end
         if (w_check) begin
            r_error <= !w_par_match || (r_count != r_length);
         end
         if (w_drop_end) begin
            r_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_router_src_rx.sv
// tb/tb_router_src_rx.sv - self-checking bench for router_src_rx

module tb_router_src_rx;

   logic       clock;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       busy;
   logic       error;
   logic [2:0] fifo_full;
   logic [2:0] wr_en;
   logic [7:0] wr_data;
   logic       pkt_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] sb_q[$];

   typedef struct {
      logic       pv;
      logic [7:0] d;
      logic [2:0] we;
      logic       hdr;
      logic       last;
      logic       err;
   } vec_t;

   vec_t vecs[15];

   router_src_rx #(
      .DATA_W   (8),
      .ADDR_W   (2),
      .NUM_DEST (3)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .pkt_valid (pkt_valid),
      .data_in   (data_in),
      .busy      (busy),
      .error     (error),
      .fifo_full (fifo_full),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .pkt_done  (pkt_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one byte, waits out busy, checks the write against the
   // scoreboard at the accepting edge, returns 1 ns after that edge.
   task automatic drive(input logic pv, input logic [7:0] d, input logic [2:0] we);
      int stalls;
      logic [10:0] exp;
      pkt_valid = pv;
      data_in   = d;
      if (we != 3'b000) sb_q.push_back({we, d});
      stalls = 0;
      @(negedge clock);
      while (busy && stalls < 50) begin
         stalls++;
         @(negedge clock);
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: busy stuck high for byte %0h", d);
      end
      if (wr_en != 3'b000 || sb_q.size() != 0) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_write", {21'd0, wr_en, wr_data}, 32'd0);
         end else begin
            exp = sb_q.pop_front();
            chk("write", {21'd0, wr_en, wr_data}, {21'd0, exp});
         end
      end else begin
         chk("no_write", {29'd0, wr_en}, 32'd0);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic end_pkt(input logic exp_err, input logic via_check);
      chk("pkt_done_pulse", {31'd0, pkt_done}, 32'd1);
      if (via_check) chk("busy_in_check", {31'd0, busy}, 32'd1);
      @(posedge clock);
      #1;
      chk("pkt_done_end", {31'd0, pkt_done}, 32'd0);
      chk("error_after_pkt", {31'd0, error}, {31'd0, exp_err});
   endtask

   task automatic run_range(input int first, input int last_i);
      for (int i = first; i <= last_i; i++) begin
         drive(vecs[i].pv, vecs[i].d, vecs[i].we);
         if (vecs[i].hdr) chk("error_clear_on_hdr", {31'd0, error}, 32'd0);
         if (vecs[i].last) begin
            pkt_valid = 1'b0;
            data_in   = 8'h00;
            end_pkt(vecs[i].err, vecs[i].we != 3'b000);
         end
      end
   endtask

   initial begin
      // good packet
      vecs[0]  = '{1'b1, 8'h0D, 3'b010, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'h11, 3'b010, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h22, 3'b010, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'h33, 3'b010, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h0D, 3'b010, 1'b0, 1'b1, 1'b0};
      // bad parity
      vecs[5]  = '{1'b1, 8'h0D, 3'b010, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'h11, 3'b010, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h22, 3'b010, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h33, 3'b010, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h0E, 3'b010, 1'b0, 1'b1, 1'b1};
      // invalid address 3
      vecs[10] = '{1'b1, 8'h07, 3'b000, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 8'hAA, 3'b000, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'hAD, 3'b000, 1'b0, 1'b1, 1'b1};
      // zero length, address 2
      vecs[13] = '{1'b1, 8'h02, 3'b100, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h02, 3'b100, 1'b0, 1'b1, 1'b0};

      resetn    = 1'b0;
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      fifo_full = 3'b000;
      #2;
      pkt_valid = 1'b1;
      data_in   = 8'h0D;
      #1;
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_error",    {31'd0, error},    32'd0);
      chk("rst_wr_en",    {29'd0, wr_en},    32'd0);
      chk("rst_wr_data",  {24'd0, wr_data},  32'd0);
      chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;

      run_range(0, 4);
      run_range(5, 9);

      // error must hold while idle
      repeat (3) @(posedge clock);
      #1;
      chk("error_hold", {31'd0, error}, 32'd1);

      run_range(10, 12);
      run_range(13, 14);

      // backpressure: FIFO 1 full for 4 cycles after payload 8'h11
      drive(1'b1, 8'h0D, 3'b010);
      drive(1'b1, 8'h11, 3'b010);
      fifo_full = 3'b010;
      pkt_valid = 1'b1;
      data_in   = 8'h22;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("bp_busy",  {31'd0, busy},  32'd1);
         chk("bp_wr_en", {29'd0, wr_en}, 32'd0);
      end
      @(posedge clock);
      #1;
      fifo_full = 3'b000;
      drive(1'b1, 8'h22, 3'b010);
      drive(1'b1, 8'h33, 3'b010);
      drive(1'b0, 8'h0D, 3'b010);
      pkt_valid = 1'b0;
      end_pkt(1'b0, 1'b1);

      // reset mid-packet
      drive(1'b1, 8'h0D, 3'b010);
      drive(1'b1, 8'h11, 3'b010);
      pkt_valid = 1'b1;
      data_in   = 8'h22;
      @(negedge clock);
      chk("pre_rst_wr_en", {29'd0, wr_en}, 32'd2);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst_wr_en",    {29'd0, wr_en},    32'd0);
      chk("async_rst_busy",     {31'd0, busy},     32'd0);
      chk("async_rst_error",    {31'd0, error},    32'd0);
      chk("async_rst_pkt_done", {31'd0, pkt_done}, 32'd0);
      data_in   = 8'h04;
      fifo_full = 3'b001;
      #1;
      chk("rst_busy_masked", {31'd0, busy}, 32'd0);
      pkt_valid = 1'b0;
      fifo_full = 3'b000;
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      drive(1'b1, 8'h04, 3'b001);
      chk("error_after_rst_hdr", {31'd0, error}, 32'd0);
      drive(1'b1, 8'h55, 3'b001);
      drive(1'b0, 8'h51, 3'b001);
      pkt_valid = 1'b0;
      end_pkt(1'b0, 1'b1);

      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
